// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl
//   Soft-start / soft-stop sequencer placed in front of the speed PWM
//   generator. Target-speed and stop commands arrive over a valid/ready
//   handshake. The speed output only ever moves one code at a time, once
//   every STEP_CYCLES clocks, so the generator never sees a jump between
//   non-adjacent speeds.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   kill        emergency off, overrides any command in the same cycle
//   cmd_valid   command present
//   cmd_ready   command accepted this cycle (OFF / HOLD only)
//   cmd_stop    1 = ramp down to 0 then disable, 0 = ramp to cmd_target
//   cmd_target  requested speed code
//   pwm_enable  generator enable
//   pwm_speed   generator speed code
//   at_target   high while holding the requested speed
//   busy        high while ramping or stopping
module pwm_ramp_ctrl #(
    parameter int STEP_CYCLES = 1024,
    parameter int SPEED_W     = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               kill,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_stop,
    input  logic [SPEED_W-1:0] cmd_target,
    output logic               pwm_enable,
    output logic [SPEED_W-1:0] pwm_speed,
    output logic               at_target,
    output logic               busy
);

    localparam int              PW      = $clog2(STEP_CYCLES + 1);
    localparam logic [PW-1:0]   PRE_MAX = PW'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {S_OFF, S_RAMP, S_HOLD, S_STOP} state_t;

    state_t             r_state, w_state_nxt;
    logic [PW-1:0]      r_pre, w_pre_nxt;
    logic [SPEED_W-1:0] r_tgt, w_tgt_nxt;
    logic [SPEED_W-1:0] r_spd, w_spd_nxt, w_spd_step;
    logic               r_en, w_en_nxt;
    logic               r_at, r_busy;
    logic               w_accept, w_tick;

    assign cmd_ready  = (r_state == S_OFF) || (r_state == S_HOLD);
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_tick     = (r_pre == PRE_MAX);
    // Stepping only happens while speed != target, so this never wraps.
    // STOP reuses the same path with the target forced to 0.
    assign w_spd_step = (r_tgt > r_spd) ? r_spd + SPEED_W'(1) : r_spd - SPEED_W'(1);

    assign pwm_enable = r_en;
    assign pwm_speed  = r_spd;
    assign at_target  = r_at;
    assign busy       = r_busy;

    always_comb begin
        w_state_nxt = r_state;
        w_pre_nxt   = r_pre;
        w_tgt_nxt   = r_tgt;
        w_spd_nxt   = r_spd;
        w_en_nxt    = r_en;
        if (kill) begin
            w_state_nxt = S_OFF;
            w_en_nxt    = 1'b0;
            w_spd_nxt   = '0;
            w_pre_nxt   = '0;
        end else begin
            unique case (r_state)
                S_OFF: begin
                    if (w_accept && !cmd_stop) begin
                        w_en_nxt    = 1'b1;
                        w_spd_nxt   = '0;
                        w_pre_nxt   = '0;
                        w_tgt_nxt   = cmd_target;
                        w_state_nxt = (cmd_target == '0) ? S_HOLD : S_RAMP;
                    end
                end
                S_RAMP, S_STOP: begin
                    // Reaching speed 0 while stopping disables on the very
                    // next edge, ahead of any prescaler activity.
                    if (r_state == S_STOP && r_spd == '0) begin
                        w_state_nxt = S_OFF;
                        w_en_nxt    = 1'b0;
                        w_pre_nxt   = '0;
                    end else if (w_tick) begin
                        w_pre_nxt = '0;
                        w_spd_nxt = w_spd_step;
                        if (r_state == S_RAMP && w_spd_step == r_tgt)
                            w_state_nxt = S_HOLD;
                    end else begin
                        w_pre_nxt = r_pre + PW'(1);
                    end
                end
                S_HOLD: begin
                    if (w_accept) begin
                        if (cmd_stop) begin
                            w_state_nxt = S_STOP;
                            w_tgt_nxt   = '0;
                            w_pre_nxt   = '0;
                        end else if (cmd_target != r_spd) begin
                            w_state_nxt = S_RAMP;
                            w_tgt_nxt   = cmd_target;
                            w_pre_nxt   = '0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_OFF;
                    w_en_nxt    = 1'b0;
                    w_spd_nxt   = '0;
                    w_pre_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_OFF;
            r_pre   <= '0;
            r_tgt   <= '0;
            r_spd   <= '0;
            r_en    <= 1'b0;
            r_at    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pre   <= w_pre_nxt;
            r_tgt   <= w_tgt_nxt;
            r_spd   <= w_spd_nxt;
            r_en    <= w_en_nxt;
            // Status flags are registered copies of the next-state decode.
            r_at    <= (w_state_nxt == S_HOLD);
            r_busy  <= (w_state_nxt == S_RAMP) || (w_state_nxt == S_STOP);
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl
//   Directed scenarios followed by random commands. The reference model
//   remembers only the last accepted command (kind, start speed, target,
//   accept cycle) and derives the expected outputs at any cycle from the
//   closed-form latency rules.
module tb_pwm_ramp_ctrl;

    localparam int STEP = 4;
    localparam int SW   = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1, kill = 1'b0, cmd_valid = 1'b0, cmd_stop = 1'b0;
    logic [SW-1:0] cmd_target = '0;
    logic          cmd_ready, pwm_enable, at_target, busy;
    logic [SW-1:0] pwm_speed;

    pwm_ramp_ctrl #(.STEP_CYCLES(STEP), .SPEED_W(SW)) dut (
        .clk(clk), .rst(rst), .kill(kill),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_stop(cmd_stop), .cmd_target(cmd_target),
        .pwm_enable(pwm_enable), .pwm_speed(pwm_speed),
        .at_target(at_target), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic          en;
        logic [SW-1:0] spd;
        logic          at;
        logic          bsy;
    } exp_t;

    int cyc    = 0;
    int m_kind = 0;   // 0 = nothing running, 1 = move a->b, 2 = stop from a
    int m_a    = 0;
    int m_b    = 0;
    int m_k    = 0;

    function automatic exp_t eval(input int t);
        exp_t e;
        int   n, d;
        e = '0;
        n = (t - m_k) / STEP;
        if (m_kind == 1) begin
            d    = (m_b > m_a) ? m_b - m_a : m_a - m_b;
            e.en = 1'b1;
            if (n >= d) begin
                e.spd = SW'(m_b);
                e.at  = 1'b1;
            end else begin
                e.spd = SW'((m_b > m_a) ? m_a + n : m_a - n);
                e.bsy = 1'b1;
            end
        end else if (m_kind == 2) begin
            if (t - m_k < m_a * STEP + 1) begin
                e.en  = 1'b1;
                e.bsy = 1'b1;
                e.spd = SW'((n >= m_a) ? 0 : m_a - n);
            end
        end
        return e;
    endfunction

    // One clock: drive at negedge, advance model at posedge, check after.
    task automatic step(input int r, input int k, input int v, input int s, input int tg);
        exp_t p, e;
        @(negedge clk);
        rst        = (r != 0);
        kill       = (k != 0);
        cmd_valid  = (v != 0);
        cmd_stop   = (s != 0);
        cmd_target = SW'(tg);
        @(posedge clk);
        p = eval(cyc);
        cyc++;
        if (r != 0 || k != 0) begin
            m_kind = 0;
        end else if (v != 0 && !p.bsy) begin
            if (!p.en) begin
                if (s == 0) begin
                    m_kind = 1; m_a = 0; m_b = tg; m_k = cyc;
                end
            end else if (s != 0) begin
                m_kind = 2; m_a = int'(p.spd); m_k = cyc;
            end else if (tg != int'(p.spd)) begin
                m_kind = 1; m_a = int'(p.spd); m_b = tg; m_k = cyc;
            end
        end
        e = eval(cyc);
        #1;
        chk("enable",    int'(pwm_enable), int'(e.en));
        chk("speed",     int'(pwm_speed),  int'(e.spd));
        chk("at_target", int'(at_target),  int'(e.at));
        chk("busy",      int'(busy),       int'(e.bsy));
        chk("cmd_ready", int'(cmd_ready),  int'(!e.bsy));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        // reset with random inputs
        for (int i = 0; i < 2; i++)
            step(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7));
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_en",    int'(pwm_enable), 0);

        // ramp up 0 -> 5
        step(0, 0, 1, 0, 5);
        chk("up_k_busy", int'(busy), 1);
        idle(20);
        chk("up_spd",   int'(pwm_speed), 5);
        chk("up_at",    int'(at_target), 1);

        // ramp down 5 -> 2 with a command held during the ramp
        step(0, 0, 1, 0, 2);
        for (int i = 0; i < 11; i++) step(0, 0, 1, 0, 7);
        idle(1);
        chk("dn_spd", int'(pwm_speed), 2);
        chk("dn_at",  int'(at_target), 1);

        // stop from 2
        step(0, 0, 1, 1, 0);
        idle(8);
        chk("stop_zero_en", int'(pwm_enable), 1);
        idle(1);
        chk("stop_off_en",  int'(pwm_enable), 0);
        chk("stop_ready",   int'(cmd_ready), 1);

        // kill mid-ramp at speed 3 with a command present
        step(0, 0, 1, 0, 6);
        idle(12);
        chk("kill_pre_spd", int'(pwm_speed), 3);
        step(0, 1, 1, 0, 1);
        chk("kill_en",  int'(pwm_enable), 0);
        chk("kill_spd", int'(pwm_speed), 0);
        // kill in HOLD drops a stop command presented alongside it
        step(0, 0, 1, 0, 0);
        step(0, 1, 1, 1, 0);
        chk("kill_hold_busy", int'(busy), 0);
        // reset mid-ramp
        step(0, 0, 1, 0, 6);
        idle(5);
        step(1, 0, 1, 0, 3);
        chk("rst_mid_en",    int'(pwm_enable), 0);
        chk("rst_mid_ready", int'(cmd_ready), 1);

        // no-ops
        step(0, 0, 1, 0, 4);
        idle(16);
        step(0, 0, 1, 0, 4);
        idle(20);
        chk("same_spd", int'(pwm_speed), 4);
        chk("same_at",  int'(at_target), 1);
        step(0, 0, 1, 1, 0);
        idle(17);
        chk("stop4_en", int'(pwm_enable), 0);
        step(0, 0, 1, 1, 3);
        chk("off_stop_en", int'(pwm_enable), 0);
        step(0, 0, 1, 0, 0);
        chk("t0_en", int'(pwm_enable), 1);
        chk("t0_at", int'(at_target), 1);

        // random traffic
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 255) == 0) ? 1 : 0,
                 ($urandom_range(0, 63) == 0) ? 1 : 0,
                 ($urandom_range(0, 7) == 0) ? 1 : 0,
                 ($urandom_range(0, 3) == 0) ? 1 : 0,
                 $urandom_range(0, 7));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
Soft-start/soft-stop sequencer for the 3-bit speed PWM generator. It accepts target-speed and stop commands over a valid/ready handshake. It drives the generator's enable and speed inputs, stepping speed one code at a time every STEP_CYCLES clocks, so the PWM output never jumps between non-adjacent speeds. It sits between the top-level pin decode and the PWM generator instance.

Parameters:
STEP_CYCLES, 1024, clocks per one-code speed step; legal range 1 to 65535; the prescaler is $clog2(STEP_CYCLES+1) bits wide.
SPEED_W, 3, width of the speed code; speed code 0 is the slowest running speed, not off.

Ports:
clk  input  1  system clock; every flop updates on the rising edge.
rst  input  1  synchronous, active-high reset.
kill  input  1  emergency off; synchronous; priority over commands.
cmd_valid  input  1  command present.
cmd_ready  output  1  command can be accepted this cycle.
cmd_stop  input  1  1 = ramp down to 0, then disable; 0 = ramp to cmd_target.
cmd_target  input  SPEED_W  requested speed code; ignored when cmd_stop=1.
pwm_enable  output  1  to the PWM generator enable input.
pwm_speed  output  SPEED_W  to the PWM generator speed input.
at_target  output  1  high in HOLD.
busy  output  1  high in RAMP or STOPPING.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All outputs are registered, except cmd_ready, which is decoded from the state register.
- Reset values (rst=1 at an edge): state=OFF, pwm_enable=0, pwm_speed=0, at_target=0, busy=0, cmd_ready=1, prescaler=0. Reset mid-ramp aborts immediately.
- Priority per edge: rst > kill > command accept > ramp step.
- kill=1 (rst=0): the next state is OFF, with pwm_enable=0, pwm_speed=0 and prescaler=0. Any command presented in the same cycle is dropped.
- Handshake: accept occurs when cmd_valid&cmd_ready at an edge. cmd_ready=1 only in OFF and HOLD. cmd_ready=0 in RAMP and STOPPING, and cmd_valid is held off by the requester.
- States:
  - OFF:
    - accept with stop=0 -> RAMP; pwm_enable=1 and pwm_speed=0 on that edge.
    - If target==0, go straight to HOLD instead.
    - accept with stop=1 -> no-op; stay OFF.
  - RAMP: the prescaler counts from 0. At count STEP_CYCLES-1:
    - pwm_speed moves one code toward the target, and the prescaler returns to 0.
    - If the new speed equals the target, the state becomes HOLD on the same edge.
  - HOLD (at_target=1):
    - accept with stop=0 and target!=pwm_speed -> RAMP, with the prescaler cleared.
    - target==pwm_speed -> accepted with no change.
    - stop=1 -> STOPPING, with the prescaler cleared.
  - STOPPING:
    - If pwm_speed==0, go to OFF on the next edge with pwm_enable=0; this check takes priority over the prescaler.
    - Otherwise step down exactly as in RAMP.
- Latency:
  - A step from a to b accepted at edge k reaches b at edge k+|a-b|*STEP_CYCLES; at_target rises on that edge.
  - Stop from HOLD at speed s: pwm_enable falls at edge k+s*STEP_CYCLES+1.
- Arithmetic and bounds:
  - Speed is saturating and never wraps; the target is always within 0..2^SPEED_W-1.
  - STEP_CYCLES=1 steps every clock.
- busy = state is RAMP or STOPPING; busy, at_target and cmd_ready are mutually consistent every cycle.

Test Plan:
All scenarios use STEP_CYCLES=4 and SPEED_W=3.
1. Reset: hold rst=1 for 2 cycles with random inputs -> pwm_enable=0, pwm_speed=0, at_target=0, busy=0, cmd_ready=1.
2. Ramp up: in OFF, accept stop=0, target=5 at edge k.
   - At k: enable=1, speed=0, busy=1, cmd_ready=0.
   - Speed = 1, 2, 3, 4, 5 at edges k+4, k+8, k+12, k+16, k+20.
   - At_target=1 and cmd_ready=1 from k+20.
3. Ramp down: from HOLD at 5, accept target=2 at edge k -> speed 4, 3, 2 at k+4, k+8, k+12, then HOLD. A cmd_valid held during the ramp is not accepted until k+12.
4. Stop: from HOLD at 2, accept stop at edge k -> speed 1 at k+4, 0 at k+8, OFF with enable=0 at k+9, cmd_ready=1.
5. Kill: assert kill for 1 cycle while ramping at speed 3, with cmd_valid=1 in the same cycle -> next edge: OFF, enable=0, speed=0, command not executed. rst=1 mid-ramp gives the reset values at the next edge.
6. No-ops:
   - HOLD at 4, accept target=4 -> no output change for 20 cycles.
   - OFF, accept stop -> stays OFF.
   - OFF, accept target=0 -> HOLD immediately with enable=1, speed=0, at_target=1.
